// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU issue sequencer and its fcsr block.
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } fpu_seq_state_t;

    localparam logic [2:0] RM_DYN     = 3'b111;
    localparam logic [1:0] CSR_FFLAGS = 2'd1;
    localparam logic [1:0] CSR_FRM    = 2'd2;
    localparam logic [1:0] CSR_FCSR   = 2'd3;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    // Encodings 5..7 are reserved once DYN has been resolved.
    function automatic logic rm_reserved(input logic [2:0] rm);
        return rm >= 3'd5;
    endfunction

endpackage

// File: rtl/fpu_fcsr.sv
// fcsr state: frm and sticky fflags, CSR read mux, and write/accumulate merge.
module fpu_fcsr
    import fpu_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       csr_wen,
    input  logic [1:0] csr_addr,
    input  logic [7:0] csr_wdata,
    input  logic       acc_en,
    input  logic [4:0] acc_flags,
    output logic [2:0] frm,
    output logic [7:0] csr_rdata
);

    fflags_t    r_fflags;
    logic [2:0] r_frm;
    fflags_t    w_fflags_base;
    fflags_t    w_fflags_nxt;
    logic [2:0] w_frm_nxt;

    // A CSR write and a DONE accumulation in the same cycle both land: write, then OR.
    always_comb begin
        w_fflags_base = r_fflags;
        w_frm_nxt     = r_frm;
        if (csr_wen) begin
            case (csr_addr)
                CSR_FFLAGS: w_fflags_base = fflags_t'(csr_wdata[4:0]);
                CSR_FRM:    w_frm_nxt     = csr_wdata[2:0];
                CSR_FCSR: begin
                    w_fflags_base = fflags_t'(csr_wdata[4:0]);
                    w_frm_nxt     = csr_wdata[7:5];
                end
                default: ;
            endcase
        end
        w_fflags_nxt = w_fflags_base | (acc_en ? fflags_t'(acc_flags) : fflags_t'(5'b0));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_fflags <= '0;
            r_frm    <= '0;
        end else begin
            r_fflags <= w_fflags_nxt;
            r_frm    <= w_frm_nxt;
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_FFLAGS: csr_rdata = {3'b0, r_fflags};
            CSR_FRM:    csr_rdata = {5'b0, r_frm};
            CSR_FCSR:   csr_rdata = {r_frm, r_fflags};
            default:    csr_rdata = '0;
        endcase
    end

    assign frm = r_frm;

endmodule

// File: rtl/fpu_issue_seq.sv
// Issue sequencer: accepts one decoded FP instruction, drives the FPU, returns the result.
module fpu_issue_seq
    import fpu_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [2:0]  rm,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [31:0] load_data,
    output logic [4:0]  f_rs1,
    output logic [4:0]  f_rs2,
    output logic [4:0]  f_rd,
    output logic [7:0]  f_funct_7,
    output logic [2:0]  frm_in,
    output logic        f_LW,
    output logic        f_SW,
    output logic        f_wen,
    output logic [31:0] dload_ext,
    input  logic        f_ready,
    input  logic [4:0]  f_flags,
    input  logic [31:0] FPU_all_out,
    output logic        done,
    output logic [31:0] result,
    output logic        illegal,
    output logic        timeout_err,
    input  logic        csr_wen,
    input  logic [1:0]  csr_addr,
    input  logic [7:0]  csr_wdata,
    output logic [7:0]  csr_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    fpu_seq_state_t r_state, w_state_nxt;

    logic [4:0]       r_rs1, r_rs2, r_rd, r_flags;
    logic [6:0]       r_funct7;
    logic [2:0]       r_rm_eff;
    logic             r_is_load, r_is_store;
    logic [31:0]      r_load_data, r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_illegal, r_timeout;

    logic [2:0] w_frm, w_rm_eff;
    logic       w_accept, w_bad_rm, w_timeout, w_hold, w_acc_en;

    assign w_rm_eff  = (rm == RM_DYN) ? w_frm : rm;
    assign w_accept  = (r_state == ST_IDLE) && instr_valid;
    assign w_bad_rm  = rm_reserved(w_rm_eff) && !is_load && !is_store;
    assign w_timeout = (r_state == ST_WAIT) && !f_ready && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_hold    = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign w_acc_en  = (r_state == ST_DONE) && !r_is_load && !r_is_store;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (instr_valid && !w_bad_rm) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (f_ready)        w_state_nxt = ST_DONE;
                else if (w_timeout) w_state_nxt = ST_IDLE;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_funct7    <= '0;
            r_rm_eff    <= '0;
            r_is_load   <= 1'b0;
            r_is_store  <= 1'b0;
            r_load_data <= '0;
            r_flags     <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_illegal   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rs1       <= rs1;
                r_rs2       <= rs2;
                r_rd        <= rd;
                r_funct7    <= funct7;
                r_rm_eff    <= w_rm_eff;
                r_is_load   <= is_load;
                r_is_store  <= is_store;
                r_load_data <= load_data;
            end
            if (r_state == ST_ISSUE)
                r_cnt <= '0;
            else if (r_state == ST_WAIT && r_cnt != '1)
                r_cnt <= r_cnt + CNT_W'(1);
            if (r_state == ST_WAIT && f_ready) begin
                r_result <= FPU_all_out;
                r_flags  <= f_flags;
            end
            r_illegal <= w_accept && w_bad_rm;
            r_timeout <= w_timeout;
        end
    end

    fpu_fcsr u_fcsr (
        .clk       (clk),
        .n_rst     (n_rst),
        .csr_wen   (csr_wen),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .acc_en    (w_acc_en),
        .acc_flags (r_flags),
        .frm       (w_frm),
        .csr_rdata (csr_rdata)
    );

    assign instr_ready = (r_state == ST_IDLE);
    assign f_rs1       = w_hold ? r_rs1 : '0;
    assign f_rs2       = w_hold ? r_rs2 : '0;
    assign f_rd        = w_hold ? r_rd  : '0;
    assign f_funct_7   = w_hold ? {1'b0, r_funct7} : '0;
    assign frm_in      = w_hold ? r_rm_eff : '0;
    assign f_LW        = (r_state == ST_ISSUE) && r_is_load;
    assign f_SW        = (r_state == ST_ISSUE) && r_is_store;
    assign f_wen       = (r_state == ST_ISSUE) && !r_is_store;
    assign dload_ext   = r_load_data;
    assign done        = (r_state == ST_DONE);
    assign result      = r_result;
    assign illegal     = r_illegal;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Directed bench for fpu_issue_seq with hand-computed expectations.
module tb_fpu_issue_seq;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        instr_valid, instr_ready;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  rm;
    logic        is_load, is_store;
    logic [31:0] load_data;
    logic [4:0]  f_rs1, f_rs2, f_rd;
    logic [7:0]  f_funct_7;
    logic [2:0]  frm_in;
    logic        f_LW, f_SW, f_wen;
    logic [31:0] dload_ext;
    logic        f_ready;
    logic [4:0]  f_flags;
    logic [31:0] FPU_all_out;
    logic        done;
    logic [31:0] result;
    logic        illegal, timeout_err;
    logic        csr_wen;
    logic [1:0]  csr_addr;
    logic [7:0]  csr_wdata, csr_rdata;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpu_issue_seq #(.TIMEOUT(8)) dut (
        .clk(clk), .n_rst(n_rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd), .rm(rm),
        .is_load(is_load), .is_store(is_store), .load_data(load_data),
        .f_rs1(f_rs1), .f_rs2(f_rs2), .f_rd(f_rd), .f_funct_7(f_funct_7),
        .frm_in(frm_in), .f_LW(f_LW), .f_SW(f_SW), .f_wen(f_wen),
        .dload_ext(dload_ext), .f_ready(f_ready), .f_flags(f_flags),
        .FPU_all_out(FPU_all_out), .done(done), .result(result),
        .illegal(illegal), .timeout_err(timeout_err),
        .csr_wen(csr_wen), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [7:0] d);
        csr_wen = 1'b1; csr_addr = a; csr_wdata = d;
        tick();
        csr_wen = 1'b0;
    endtask

    task automatic csr_read(input string tag, input logic [1:0] a, input logic [7:0] exp);
        csr_addr = a;
        #1;
        check(tag, 32'(csr_rdata), 32'(exp));
    endtask

    task automatic issue(input logic [6:0] f7, input logic [2:0] r, input logic ld, input logic st);
        funct7 = f7; rm = r; is_load = ld; is_store = st;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; instr_valid = 1'b0; funct7 = '0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
        rm = '0; is_load = 1'b0; is_store = 1'b0; load_data = '0; f_ready = 1'b0;
        f_flags = '0; FPU_all_out = '0; csr_wen = 1'b0; csr_addr = 2'd3; csr_wdata = '0;
        #22;
        check("rst_ready", 32'(instr_ready), 1);
        check("rst_done", 32'(done), 0);
        check("rst_result", result, 0);
        check("rst_wen", 32'(f_wen), 0);
        csr_read("rst_fcsr", 2'd3, 8'h00);
        @(posedge clk); #1; n_rst = 1'b1;
        tick();

        // static rm
        issue(7'd0, 3'd1, 1'b0, 1'b0);
        check("s_frm_in", 32'(frm_in), 1);
        check("s_wen", 32'(f_wen), 1);
        check("s_rs1", 32'(f_rs1), 1);
        check("s_rd", 32'(f_rd), 3);
        tick();
        check("s_wait_wen", 32'(f_wen), 0);
        check("s_wait_frm", 32'(frm_in), 1);
        tick(); tick(); tick();
        f_ready = 1'b1; f_flags = 5'h01; FPU_all_out = 32'h40400000;
        tick();
        f_ready = 1'b0; f_flags = '0;
        check("s_done", 32'(done), 1);
        check("s_result", result, 32'h40400000);
        tick();
        check("s_done_off", 32'(done), 0);
        csr_read("s_fflags", 2'd1, 8'h01);

        // dynamic rm, plus frm write mid-instruction
        csr_write(2'd3, 8'h85);
        csr_read("d_fcsr", 2'd3, 8'h85);
        issue(7'd1, 3'd7, 1'b0, 1'b0);
        check("d_frm_in", 32'(frm_in), 4);
        check("d_funct", 32'(f_funct_7), 1);
        tick();
        csr_write(2'd2, 8'h02);
        check("d_frm_hold", 32'(frm_in), 4);
        f_ready = 1'b1;
        tick();
        f_ready = 1'b0;
        tick();
        csr_read("d_fcsr2", 2'd3, 8'h45);

        // reserved dynamic rm
        csr_write(2'd2, 8'h06);
        funct7 = 7'd0; rm = 3'd7; instr_valid = 1'b1;
        #1;
        check("i_ready_pre", 32'(instr_ready), 1);
        tick();
        instr_valid = 1'b0;
        check("i_illegal", 32'(illegal), 1);
        check("i_ready", 32'(instr_ready), 1);
        check("i_wen", 32'(f_wen), 0);
        tick();
        check("i_illegal_off", 32'(illegal), 0);
        check("i_wen2", 32'(f_wen), 0);

        // load with DYN resolving to a reserved mode is still issued
        load_data = 32'h3F800000;
        issue(7'd0, 3'd7, 1'b1, 1'b0);
        load_data = '0;
        check("l_lw", 32'(f_LW), 1);
        check("l_wen", 32'(f_wen), 1);
        check("l_dload", dload_ext, 32'h3F800000);
        tick();
        check("l_lw_off", 32'(f_LW), 0);
        check("l_wen_off", 32'(f_wen), 0);
        f_ready = 1'b1; f_flags = 5'h1F; FPU_all_out = 32'h3F800000;
        tick();
        f_ready = 1'b0; f_flags = '0;
        check("l_done", 32'(done), 1);
        tick();
        csr_read("l_fflags", 2'd1, 8'h05);

        // store
        csr_write(2'd2, 8'h00);
        issue(7'd0, 3'd0, 1'b0, 1'b1);
        check("st_sw", 32'(f_SW), 1);
        check("st_wen", 32'(f_wen), 0);
        tick();
        f_ready = 1'b1; f_flags = 5'h1F; FPU_all_out = 32'hDEADBEEF;
        tick();
        f_ready = 1'b0; f_flags = '0;
        check("st_done", 32'(done), 1);
        check("st_result", result, 32'hDEADBEEF);
        tick();
        csr_read("st_fflags", 2'd1, 8'h05);

        // timeout
        issue(7'd2, 3'd0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 7; i++) tick();
        check("t_early", 32'(timeout_err), 0);
        check("t_busy", 32'(instr_ready), 0);
        tick();
        check("t_pulse", 32'(timeout_err), 1);
        check("t_idle", 32'(instr_ready), 1);
        check("t_nodone", 32'(done), 0);
        tick();
        check("t_pulse_off", 32'(timeout_err), 0);
        csr_read("t_fflags", 2'd1, 8'h05);

        // CSR write colliding with accumulation
        csr_write(2'd1, 8'h00);
        issue(7'd0, 3'd0, 1'b0, 1'b0);
        tick();
        f_ready = 1'b1; f_flags = 5'h10;
        tick();
        f_ready = 1'b0; f_flags = '0;
        check("c_done", 32'(done), 1);
        csr_write(2'd1, 8'h02);
        csr_read("c_fflags", 2'd1, 8'h12);

        // asynchronous reset mid-WAIT
        rs1 = 5'd5;
        issue(7'd0, 3'd0, 1'b0, 1'b0);
        tick();
        check("r_wait_rs1", 32'(f_rs1), 5);
        #2 n_rst = 1'b0;
        #1;
        check("r_ready", 32'(instr_ready), 1);
        check("r_rs1", 32'(f_rs1), 0);
        check("r_done", 32'(done), 0);
        csr_read("r_fcsr", 2'd3, 8'h00);
        tick();
        n_rst = 1'b1;
        f_ready = 1'b1;
        tick();
        f_ready = 1'b0;
        check("r_ready_ignored", 32'(done), 0);
        tick();
        check("r_no_done", 32'(done), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_issue_seq.md
# fpu_issue_seq

Issue sequencer between the integer pipeline's decode/execute boundary and the FPU top level. It accepts one decoded floating-point instruction at a time and resolves the dynamic rounding mode. It drives the FPU control strobes, waits for `f_ready`, and returns the result to the pipeline. It also owns the `fcsr` state (`frm` and the sticky `fflags`) and exposes a CSR read/write port.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum cycles spent in WAIT before aborting.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  decoded FP instruction present.
- `instr_ready`  out  1  sequencer can accept an instruction.
- `funct7`  in  7  FP operation selector.
- `rs1`, `rs2`, `rd`  in  5 each  register indices.
- `rm`  in  3  instruction rounding field; `3'b111` = DYN.
- `is_load`, `is_store`  in  1 each  FLW / FSW.
- `load_data`  in  32  memory data for FLW.
- `f_rs1`, `f_rs2`, `f_rd`  out  5 each  to FPU.
- `f_funct_7`  out  8  `{1'b0, funct7}`.
- `frm_in`  out  3  resolved rounding mode.
- `f_LW`, `f_SW`, `f_wen`  out  1 each  FPU strobes.
- `dload_ext`  out  32  latched `load_data`.
- `f_ready`  in  1  FPU completion.
- `f_flags`  in  5  `{NV,DZ,OF,UF,NX}`.
- `FPU_all_out`  in  32  FPU result / store data.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  32  `FPU_all_out` captured at completion.
- `illegal`  out  1  one-cycle pulse: invalid resolved rounding mode.
- `timeout_err`  out  1  one-cycle pulse: WAIT exceeded `TIMEOUT`.
- `csr_wen`  in  1  CSR write strobe.
- `csr_addr`  in  2  `1` = fflags, `2` = frm, `3` = fcsr (`0` ignored).
- `csr_wdata`  in  8  write data.
- `csr_rdata`  out  8  combinational read of the addressed CSR.

## Operation
States: IDLE, ISSUE, WAIT, DONE.

- **IDLE**
  - `instr_ready=1`.
  - On `instr_valid`, latch all instruction fields and `load_data`.
  - Resolve `rm_eff = (rm==7) ? frm : rm`.
  - If `rm_eff` is 5, 6 or 7, pulse `illegal` and stay in IDLE. The rm check applies only when the instruction is not a load or store.
  - Otherwise go to ISSUE.
- **ISSUE** (one cycle)
  - Drive `f_rs1`, `f_rs2`, `f_rd`, `f_funct_7`, `frm_in` from the latches.
  - `f_LW = is_load`, `f_SW = is_store`, `f_wen = !is_store`.
  - Go to WAIT.
- **WAIT**
  - Hold the `f_*` index, funct and frm outputs; strobes `f_LW`/`f_SW`/`f_wen` are low.
  - Increment the timeout counter each cycle.
  - On `f_ready`: capture `FPU_all_out` into `result` and go to DONE.
  - If the counter reaches `TIMEOUT-1` without `f_ready`: pulse `timeout_err`, go to IDLE, and leave `fflags` unchanged.
- **DONE** (one cycle)
  - `done=1`.
  - For non-load, non-store ops, `fflags <= fflags | f_flags_latched`. `f_flags` is sampled with `f_ready`.
  - Go to IDLE.
- **CSR rules**
  - `csr_rdata`: fflags → `{3'b0, fflags}`; frm → `{5'b0, frm}`; fcsr → `{frm, fflags}`.
  - Writes take effect next edge: fflags ← `wdata[4:0]`; frm ← `wdata[2:0]`; fcsr ← `{wdata[7:5], wdata[4:0]}`.
- **CSR write colliding with DONE accumulation:** the final fflags is `written value | f_flags_latched`.
- **frm write during an instruction:** does not affect it; rm was resolved in IDLE.

## Timing
- **Reset values:** every output 0 except `instr_ready=1`; `fflags=0`, `frm=0`, state IDLE, counter 0.
- **Reset mid-operation:** immediate return to IDLE; `done` is never asserted for the aborted instruction.
- **Latency:** accept edge → ISSUE → WAIT (≥1 cycle) → DONE.
  - If `f_ready` is high in the first WAIT cycle, `done` appears 3 cycles after acceptance.
  - Next instruction is accepted in the cycle after DONE.
- **`f_ready`:** ignored outside WAIT.
- **`instr_valid`:** ignored outside IDLE. The pipeline holds `instr_valid` and fields until it sees `instr_ready`.
- **Counter:** width `$clog2(TIMEOUT)`, saturating, cleared on entry to WAIT.

## Structure
- **Shared package `fpu_pkg`:**
  - state enum `fpu_seq_state_t`;
  - `RM_DYN = 3'b111`;
  - CSR address constants `CSR_FFLAGS`, `CSR_FRM`, `CSR_FCSR`;
  - `fflags_t` packed struct `{nv, dz, of, uf, nx}`.
- **Sub-module:** one, `fpu_fcsr`, holding the frm/fflags registers, CSR read mux, and the write/accumulate merge. The FSM and latches stay in the top module.

## Test plan
1. **Static rm:** FADD (`funct7=0`), `rm=1`; FPU raises `f_ready` 4 cycles into WAIT with `f_flags=5'b00001` and `FPU_all_out=0x40400000` → `frm_in=1` during ISSUE; `done` with `result=0x40400000`; fflags reads `0x01`.
2. **Dynamic rm:** write fcsr `0x85` (frm=4, fflags=5), then issue `rm=7` → `frm_in=4`. Invalid case: write frm=6, issue `rm=7` → `illegal` pulse, no `f_wen`, `instr_ready` stays 1.
3. **Load:** FLW with `load_data=0x3F800000` → `f_LW` and `f_wen` high exactly one cycle; `dload_ext=0x3F800000`; fflags unchanged after `done` even with `f_flags=5'h1F`.
4. **Store:** FSW → `f_SW=1`, `f_wen=0` in ISSUE; `result` equals `FPU_all_out` (`0xDEADBEEF`).
5. **Timeout:** `TIMEOUT=8`, never assert `f_ready` → `timeout_err` pulse 8 cycles after WAIT entry; state IDLE; no `done`.
6. **Collision and reset:** CSR write fflags=`0x02` in the DONE cycle with latched flags `0x10` → fflags reads `0x12`. Deassert `n_rst` mid-WAIT → all outputs reset asynchronously; fflags=0.
